vec_result_collector: RTL and testbench
=======================================

Name: vec_result_collector

Overview:
- Sits directly downstream of vec_alu_wrapper; consumes per-lane element results (vd0..vd3) and their bit offsets (regi0..regi3) each cycle.
- Assembles them into one VLEN-bit destination vector, tracking byte coverage.
- On ALU completion, presents the assembled vector to the vector register file write port with a valid/ready handshake.

Parameters:
- VLEN, 128, vector register width in bits (multiple of 64).
- LANE_WIDTH, 3'b100, log2 of lane datapath width in bits (3..6).
- IDX_W, 10, width of lane bit-offset inputs.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a new collection; accepted only when busy=0.
- vd_addr  in  5  destination vector register index, latched on accepted start.
- vsew  in  3  element width code (0=8b .. 3=64b), latched on accepted start.
- lane_valid  in  4  per-lane beat valid (lane k uses vdk/regik).
- vd0, vd1, vd2, vd3  in  64 each  lane results, element in low bits.
- regi0, regi1, regi2, regi3  in  IDX_W each  bit offset of lane element in destination.
- alu_done  in  1  ALU finished; beats in the same cycle are still collected.
- busy  out  1  high in COLLECT or WRITE.
- wb_valid  out  1  write request to register file.
- wb_ready  in  1  register file accepts write.
- wb_addr  out  5  latched vd_addr.
- wb_data  out  VLEN  assembled vector.
- wb_err  out  1  valid with wb_valid: incomplete coverage or out-of-range beat occurred.

Behaviour:
- Reset (async): state=IDLE; busy=0, wb_valid=0, wb_addr=0, wb_data=0, wb_err=0; coverage mask=0.
- Piece width W = min(8<<vsew, 1<<LANE_WIDTH) bits; low W bits of vdk written at [regik +: W].
- States: IDLE, COLLECT, WRITE.
- IDLE:
  - On start: latch vd_addr and vsew, clear buffer to 0, clear the VLEN/8-bit byte mask, clear the error flag, go to COLLECT.
  - busy=1 from the next cycle.
- COLLECT, each cycle, for each lane k with lane_valid[k]:
  - If regik+W <= VLEN: write the piece and set its mask bytes.
  - Otherwise: drop the beat and set the sticky error flag.
  - Same-cycle overlapping writes: higher lane index wins.
  - Rewrite of already-covered bytes is legal (last write wins) and is not an error.
  - lane_valid and alu_done are ignored outside COLLECT; start is ignored while busy.
- alu_done in COLLECT: apply that cycle's beats, then go to WRITE. wb_valid=1 in the cycle after alu_done (1-cycle latency).
- WRITE:
  - wb_data and wb_addr are stable while wb_valid=1.
  - wb_err = sticky error OR (mask != all-ones).
  - On wb_valid&&wb_ready: go to IDLE; wb_valid=0 and busy=0 next cycle.
  - wb_data keeps its last value while IDLE.
- start in the same cycle as the handshake is ignored (busy=1); it is accepted one cycle later.
- Reset mid-COLLECT or mid-WRITE: immediate abort to IDLE; no write is issued.
- Ordering: the latched vsew sets W; vsew input changes during COLLECT are ignored.

Decomposition:
- Shared package vec_pkg: VLEN default, SEW codes (SEW8..SEW64), state enum {IDLE, COLLECT, WRITE}, function piece_width(vsew, lane_width).
- One sub-module, vec_lane_merge: combinational masked insert of a single piece into a VLEN vector plus its byte mask. Instantiate 4×, chained lane0→lane3 so the higher lane wins.

Test Plan:
- LANE_WIDTH=4, vsew=0, one lane, 16 beats at regi0=0,8,...,120 carrying bytes of 128'h3232eeeed0231467d02314673232eeee, alu_done on last beat -> wb_valid next cycle; wb_data equals that value; wb_err=0; wb_addr as latched.
- vsew=3, LANE_WIDTH=4, lanes 0..3 valid with regi 0/16/32/48, then 64/80/96/112 -> W=16; wb_data=128'h3332eeeed1241567d12415683332eeee; wb_err=0.
- Same as the first case, but omit the beat at regi0=40 -> wb_err=1; bits [47:40]=0.
- Beat with regi0=120, vsew=1, LANE_WIDTH=4 (W=16) -> dropped; wb_err=1; other bytes intact.
- Hold wb_ready=0 for 5 cycles -> wb_valid and wb_data stable throughout; a start pulse during the wait is ignored; busy drops 1 cycle after the handshake.
- Assert reset 3 cycles into COLLECT -> all outputs 0 immediately; a subsequent start/collect runs normally with a fresh buffer.

Source files
------------

// File: rtl/vec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_pkg : shared types and helpers for the vector result collector         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vec_pkg;

    localparam int VLEN_DEFAULT = 128;

    typedef enum logic [2:0] {
        SEW8  = 3'd0,
        SEW16 = 3'd1,
        SEW32 = 3'd2,
        SEW64 = 3'd3
    } sew_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    // Piece width is the element width, capped by the lane datapath width.
    function automatic logic [6:0] piece_width(input logic [2:0] vsew, input int lane_width);
        int sew_bits;
        int lane_bits;
        sew_bits  = 8 << vsew;
        lane_bits = 1 << lane_width;
        return 7'((sew_bits < lane_bits) ? sew_bits : lane_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_lane_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_lane_merge : masked insert of one lane piece into a vector + byte mask |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vec_lane_merge #(
    parameter int VLEN  = 128,
    parameter int IDX_W = 10
) (
    input  logic                i_en,
    input  logic [6:0]          i_width,
    input  logic [63:0]         i_piece,
    input  logic [IDX_W-1:0]    i_offset,
    input  logic [VLEN-1:0]     i_vec,
    input  logic [VLEN/8-1:0]   i_mask,
    output logic [VLEN-1:0]     o_vec,
    output logic [VLEN/8-1:0]   o_mask,
    output logic                o_err
);

    localparam int C_AW    = $clog2(VLEN) + 1;
    localparam int C_EXT_W = ((IDX_W > C_AW) ? IDX_W : C_AW) + 1;

    logic [C_EXT_W-1:0] w_end;
    logic               w_in_range;
    logic               w_write;
    logic [63:0]        w_piece_mask;
    logic [VLEN-1:0]    w_bit_mask;
    logic [VLEN-1:0]    w_data;
    logic [VLEN/8-1:0]  w_byte_hit;

    // Extended width so offset + width cannot wrap before the range test.
    assign w_end        = C_EXT_W'(i_offset) + C_EXT_W'(i_width);
    assign w_in_range   = (w_end <= C_EXT_W'(VLEN));
    assign w_write      = i_en && w_in_range;
    assign w_piece_mask = (i_width >= 7'd64) ? '1 : ((64'd1 << i_width) - 64'd1);
    assign w_bit_mask   = VLEN'(w_piece_mask) << i_offset;
    assign w_data       = VLEN'(i_piece & w_piece_mask) << i_offset;

    always_comb begin
        w_byte_hit = '0;
        for (int b = 0; b < VLEN/8; b++) begin
            w_byte_hit[b] = |w_bit_mask[8*b +: 8];
        end
    end

    assign o_vec  = w_write ? ((i_vec & ~w_bit_mask) | w_data) : i_vec;
    assign o_mask = w_write ? (i_mask | w_byte_hit) : i_mask;
    assign o_err  = i_en && !w_in_range;

endmodule
`default_nettype wire

// File: rtl/vec_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_result_collector : assembles per-lane ALU results into one vector and  |
// | hands it to the register file write port with a valid/ready handshake.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vec_result_collector
    import vec_pkg::*;
#(
    parameter int VLEN       = VLEN_DEFAULT,
    parameter int LANE_WIDTH = 3'b100,
    parameter int IDX_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       vd_addr,
    input  logic [2:0]       vsew,
    input  logic [3:0]       lane_valid,
    input  logic [63:0]      vd0,
    input  logic [63:0]      vd1,
    input  logic [63:0]      vd2,
    input  logic [63:0]      vd3,
    input  logic [IDX_W-1:0] regi0,
    input  logic [IDX_W-1:0] regi1,
    input  logic [IDX_W-1:0] regi2,
    input  logic [IDX_W-1:0] regi3,
    input  logic             alu_done,
    output logic             busy,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_addr,
    output logic [VLEN-1:0]  wb_data,
    output logic             wb_err
);

    state_e             r_state;
    state_e             w_state_next;
    logic [4:0]         r_addr;
    logic [2:0]         r_vsew;
    logic [VLEN-1:0]    r_buf;
    logic [VLEN/8-1:0]  r_mask;
    logic               r_err;

    logic               w_collect;
    logic [6:0]         w_width;
    logic [VLEN-1:0]    w_vec1, w_vec2, w_vec3, w_vec4;
    logic [VLEN/8-1:0]  w_mask1, w_mask2, w_mask3, w_mask4;
    logic [3:0]         w_lane_err;

    assign w_collect = (r_state == COLLECT);
    assign w_width   = piece_width(r_vsew, LANE_WIDTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)    w_state_next = COLLECT;
            COLLECT: if (alu_done) w_state_next = WRITE;
            WRITE:   if (wb_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Chained lane0 -> lane3 so a higher lane overrides overlapping bits.
    vec_lane_merge #(.VLEN(VLEN), .IDX_W(IDX_W)) u_merge0 (
        .i_en(w_collect && lane_valid[0]), .i_width(w_width), .i_piece(vd0), .i_offset(regi0),
        .i_vec(r_buf), .i_mask(r_mask), .o_vec(w_vec1), .o_mask(w_mask1), .o_err(w_lane_err[0])
    );
    vec_lane_merge #(.VLEN(VLEN), .IDX_W(IDX_W)) u_merge1 (
        .i_en(w_collect && lane_valid[1]), .i_width(w_width), .i_piece(vd1), .i_offset(regi1),
        .i_vec(w_vec1), .i_mask(w_mask1), .o_vec(w_vec2), .o_mask(w_mask2), .o_err(w_lane_err[1])
    );
    vec_lane_merge #(.VLEN(VLEN), .IDX_W(IDX_W)) u_merge2 (
        .i_en(w_collect && lane_valid[2]), .i_width(w_width), .i_piece(vd2), .i_offset(regi2),
        .i_vec(w_vec2), .i_mask(w_mask2), .o_vec(w_vec3), .o_mask(w_mask3), .o_err(w_lane_err[2])
    );
    vec_lane_merge #(.VLEN(VLEN), .IDX_W(IDX_W)) u_merge3 (
        .i_en(w_collect && lane_valid[3]), .i_width(w_width), .i_piece(vd3), .i_offset(regi3),
        .i_vec(w_vec3), .i_mask(w_mask3), .o_vec(w_vec4), .o_mask(w_mask4), .o_err(w_lane_err[3])
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_vsew <= '0;
            r_buf  <= '0;
            r_mask <= '0;
            r_err  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_addr <= vd_addr;
            r_vsew <= vsew;
            r_buf  <= '0;
            r_mask <= '0;
            r_err  <= 1'b0;
        end else if (w_collect) begin
            r_buf  <= w_vec4;
            r_mask <= w_mask4;
            r_err  <= r_err | (|w_lane_err);
        end
    end

    assign busy     = (r_state != IDLE);
    assign wb_valid = (r_state == WRITE);
    assign wb_addr  = r_addr;
    assign wb_data  = r_buf;
    assign wb_err   = wb_valid && (r_err || !(&r_mask));

endmodule
`default_nettype wire

// File: tb/tb_vec_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vec_result_collector : scoreboard bench for vec_result_collector        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vec_result_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   vd_addr;
    logic [2:0]   vsew;
    logic [3:0]   lane_valid;
    logic [63:0]  vd [4];
    logic [9:0]   regi [4];
    logic         alu_done;
    logic         busy;
    logic         wb_valid;
    logic         wb_ready;
    logic [4:0]   wb_addr;
    logic [127:0] wb_data;
    logic         wb_err;

    always #5 clk = ~clk;

    vec_result_collector #(.VLEN(128), .LANE_WIDTH(4), .IDX_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .vd_addr(vd_addr), .vsew(vsew),
        .lane_valid(lane_valid),
        .vd0(vd[0]), .vd1(vd[1]), .vd2(vd[2]), .vd3(vd[3]),
        .regi0(regi[0]), .regi1(regi[1]), .regi2(regi[2]), .regi3(regi[3]),
        .alu_done(alu_done), .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_err(wb_err)
    );

    typedef struct {
        logic [4:0]   addr;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [127:0] E1 = 128'h3232eeeed0231467d02314673232eeee;
    localparam logic [127:0] E2 = 128'h3332eeeed1241567d12415683332eeee;
    localparam logic [127:0] E4 = 128'h0123456789abcdeffedcba9876543210;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [127:0] d, input logic e);
        exp_t x;
        x.addr = a;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: compare on every accepted write.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, no write expected", wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_addr", 128'(wb_addr), 128'(e.addr));
                check("wb_err", 128'(wb_err), 128'(e.err));
            end
        end
    end

    // Stall checker: while a write is held off, the request must not change.
    logic         prev_hold = 1'b0;
    logic [127:0] prev_data;
    logic [4:0]   prev_addr;
    always @(negedge clk) begin
        if (prev_hold && !reset) begin
            check("hold_valid", 128'(wb_valid), 128'(1'b1));
            check("hold_data", wb_data, prev_data);
            check("hold_addr", 128'(wb_addr), 128'(prev_addr));
        end
        prev_hold <= wb_valid && !wb_ready;
        prev_data <= wb_data;
        prev_addr <= wb_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start      = 1'b0;
        alu_done   = 1'b0;
        lane_valid = '0;
    endtask

    task automatic set_lane(input int k, input logic [63:0] d, input int off);
        vd[k]         = d;
        regi[k]       = off[9:0];
        lane_valid[k] = 1'b1;
    endtask

    task automatic do_start(input logic [4:0] a, input logic [2:0] s);
        start   = 1'b1;
        vd_addr = a;
        vsew    = s;
        tick();
        check("busy_after_start", 128'(busy), 128'(1'b1));
        vsew = 3'd7;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy still %b after 50 cycles, required 0", busy);
        end
    endtask

    // Byte-wide beats on lane 0; upper junk bits must be masked off.
    task automatic run_bytes(input logic [4:0] a, input logic [127:0] val, input int skip, input int nbytes);
        do_start(a, 3'd0);
        for (int i = 0; i < nbytes; i++) begin
            if (i != skip) set_lane(0, {56'hFFFF_FFFF_FFFF_FF, val[8*i +: 8]}, 8*i);
            if (i == nbytes - 1) alu_done = 1'b1;
            tick();
        end
        check("valid_latency", 128'(wb_valid), 128'(1'b1));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        vd_addr    = '0;
        vsew       = '0;
        lane_valid = '0;
        alu_done   = 1'b0;
        wb_ready   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vd[k]   = '0;
            regi[k] = '0;
        end
        #2;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(wb_valid), 128'(0));
        check("rst_data", wb_data, 128'(0));
        check("rst_addr", 128'(wb_addr), 128'(0));
        check("rst_err", 128'(wb_err), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // 1: sixteen byte beats, full coverage
        push_exp(5'd3, E1, 1'b0);
        run_bytes(5'd3, E1, -1, 16);
        wait_idle();

        // 2: four lanes, two cycles, W capped at 16 by the lane width
        push_exp(5'd17, E2, 1'b0);
        do_start(5'd17, 3'd3);
        for (int k = 0; k < 4; k++) set_lane(k, {48'hABCD_1234_5678, E2[16*k +: 16]}, 16*k);
        tick();
        for (int k = 0; k < 4; k++) set_lane(k, {48'hABCD_1234_5678, E2[64 + 16*k +: 16]}, 64 + 16*k);
        alu_done = 1'b1;
        tick();
        check("valid_latency", 128'(wb_valid), 128'(1'b1));
        wait_idle();

        // 3: missing byte 5 -> incomplete coverage
        push_exp(5'd4, E1 & ~(128'hFF << 40), 1'b1);
        run_bytes(5'd4, E1, 5, 16);
        wait_idle();

        // 4: W=16 pieces, then an out-of-range beat at 120 that must be dropped
        push_exp(5'd21, E4, 1'b1);
        do_start(5'd21, 3'd1);
        for (int i = 0; i < 8; i++) begin
            set_lane(0, {48'hFFFF_FFFF_FFFF, E4[16*i +: 16]}, 16*i);
            tick();
        end
        set_lane(0, 64'hFFFF_FFFF_FFFF_FFFF, 120);
        alu_done = 1'b1;
        tick();
        check("valid_latency", 128'(wb_valid), 128'(1'b1));
        wait_idle();

        // 5: overlap (higher lane wins), rewrite, then a stalled write port
        push_exp(5'd9, 128'h664455, 1'b1);
        do_start(5'd9, 3'd0);
        set_lane(0, 64'h11, 0);
        set_lane(1, 64'h22, 0);
        set_lane(2, 64'h33, 8);
        set_lane(3, 64'h44, 8);
        tick();
        set_lane(0, 64'h55, 0);
        set_lane(1, 64'h66, 16);
        alu_done = 1'b1;
        wb_ready = 1'b0;
        tick();
        check("valid_latency", 128'(wb_valid), 128'(1'b1));
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                start   = 1'b1;
                vd_addr = 5'd30;
            end
            tick();
            check("stall_busy", 128'(busy), 128'(1'b1));
        end
        wb_ready = 1'b1;
        tick();
        check("busy_after_hs", 128'(busy), 128'(0));
        check("valid_after_hs", 128'(wb_valid), 128'(0));
        check("data_kept_idle", wb_data, 128'h664455);

        // 6: reset during COLLECT aborts, then a fresh collection
        do_start(5'd12, 3'd0);
        for (int i = 0; i < 3; i++) begin
            set_lane(0, 64'hA0 + 64'(i), 8*i);
            tick();
        end
        reset = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_valid", 128'(wb_valid), 128'(0));
        check("abort_data", wb_data, 128'(0));
        check("abort_addr", 128'(wb_addr), 128'(0));
        check("abort_err", 128'(wb_err), 128'(0));
        tick();
        reset = 1'b0;
        tick();
        push_exp(5'd7, {64'h0, E1[63:0]}, 1'b1);
        run_bytes(5'd7, E1, -1, 8);
        wait_idle();

        tick();
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
